// File: rtl/hetszegmens_pkg.sv
// hetszegmens_pkg: shared constants for the multiplexed seven-segment driver.
//   SEG_LUT    - active-low a..g patterns for hex 0..F, dp bit (bit 0) held off
//   NUM_PHASES - PWM phases per digit slot
//   SEG_OFF    - all segments and dp dark
package hetszegmens_pkg;

    localparam int         NUM_PHASES = 8;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    // SEG[7..1] = a..g, SEG[0] = dp; a 0 lights the segment.
    // The list is written from entry F down to entry 0.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/hetszegmens_if.sv
// hetszegmens_if: display request inputs and pin-side outputs of the driver.
//   din/dp/blank/blink/lz_en/bright - requests from the datapath
//   AN/SEG/frame_start              - board pins and frame marker
// The master modport belongs to the datapath side and the slave modport to the driver.
interface hetszegmens_if #(parameter int DIGITS = 4);
    logic [4*DIGITS-1:0] din;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
    logic                lz_en;
    logic [2:0]          bright;
    logic [DIGITS-1:0]   AN;
    logic [7:0]          SEG;
    logic                frame_start;

    modport master (output din, dp, blank, blink, lz_en, bright,
                    input  AN, SEG, frame_start);
    modport slave  (input  din, dp, blank, blink, lz_en, bright,
                    output AN, SEG, frame_start);
endinterface

// File: rtl/hetszegmens_dekoder.sv
// hetszegmens_dekoder: combinational segment decode for the digit being scanned.
//   nib  - hex nibble
//   dp   - decimal point request
//   supp - leading zero suppressed; a..g off, dp still honoured
//   dark - digit unlit; SEG forced to SEG_OFF
//   seg  - active-low segment pattern
module hetszegmens_dekoder
    import hetszegmens_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       supp,
    input  logic       dark,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!dark) begin
            seg    = supp ? SEG_OFF : hex_to_seg(nib);
            seg[0] = ~dp;
        end
    end

endmodule

// File: rtl/hetszegmens_n.sv
// hetszegmens_n: multiplexed seven-segment driver for common-anode digits.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - slave side of hetszegmens_if (requests in; AN/SEG/frame_start out)
// Stage 1 holds the scan state: divider, phase, idx, frame/blink counters and the
// per-frame snapshot. Stage 2 registers AN/SEG/frame_start from that state.
module hetszegmens_n
    import hetszegmens_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_HZ       = 16_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    hetszegmens_if.slave   bus
);

    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int PH_LEN = DIV / NUM_PHASES;
    localparam int CW     = $clog2(DIV);
    localparam int PW     = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
    localparam int IW     = $clog2(DIGITS);
    localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       pc_q, pc_d;
    logic [2:0]          ph_q, ph_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FW-1:0]       fc_q, fc_d;
    logic                blink_st_q, blink_st_d;
    logic [4*DIGITS-1:0] din_s_q, din_s_d;
    logic [DIGITS-1:0]   dp_s_q, dp_s_d, blank_s_q, blank_s_d, blink_s_q, blink_s_d;
    logic                lz_s_q, lz_s_d;
    logic [2:0]          bright_s_q, bright_s_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                fs_q, fs_d;

    logic                tick, wrap, pc_last, seen, cur_dark;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          cur_nib;

    // Scan timing, frame/blink counters and the frame-start snapshot.
    always_comb begin
        tick       = (cnt_q == CW'(DIV - 1));
        wrap       = tick && (idx_q == IW'(DIGITS - 1));
        pc_last    = (pc_q == PW'(PH_LEN - 1));
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        pc_d       = pc_last ? '0 : pc_q + 1'b1;
        // DIV is a multiple of 8, so the phase wraps 7 -> 0 on the tick edge.
        ph_d       = pc_last ? ph_q + 3'd1 : ph_q;
        idx_d      = idx_q;
        fc_d       = fc_q;
        blink_st_d = blink_st_q;
        din_s_d    = din_s_q;
        dp_s_d     = dp_s_q;
        blank_s_d  = blank_s_q;
        blink_s_d  = blink_s_q;
        lz_s_d     = lz_s_q;
        bright_s_d = bright_s_q;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
        if (wrap) begin
            din_s_d    = bus.din;
            dp_s_d     = bus.dp;
            blank_s_d  = bus.blank;
            blink_s_d  = bus.blink;
            lz_s_d     = bus.lz_en;
            bright_s_d = bus.bright;
            if (fc_q == FW'(BLINK_FRAMES - 1)) begin
                fc_d       = '0;
                blink_st_d = ~blink_st_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    // Leading-zero mask: a digit is suppressed while no nonzero nibble has been
    // seen above it; digit 0 always shows.
    always_comb begin
        seen = ~lz_s_q;
        supp = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (din_s_q[4*i +: 4] != 4'd0) seen = 1'b1;
            supp[i] = ~seen;
        end
    end

    // Stage-2 next values for the digit currently addressed by idx.
    always_comb begin
        cur_nib  = din_s_q[4*int'(idx_q) +: 4];
        cur_dark = blank_s_q[idx_q] | (blink_s_q[idx_q] & blink_st_q) | (ph_q > bright_s_q);
        an_d     = '1;
        if (!cur_dark) an_d[idx_q] = 1'b0;
        fs_d     = (idx_q == '0) && (cnt_q == '0);
    end

    hetszegmens_dekoder u_dekoder (
        .nib  (cur_nib),
        .dp   (dp_s_q[idx_q]),
        .supp (supp[idx_q]),
        .dark (cur_dark),
        .seg  (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            pc_q       <= '0;
            ph_q       <= '0;
            idx_q      <= IW'(DIGITS - 1);
            fc_q       <= '0;
            blink_st_q <= 1'b0;
            din_s_q    <= '0;
            dp_s_q     <= '0;
            blank_s_q  <= '0;
            blink_s_q  <= '0;
            lz_s_q     <= 1'b0;
            bright_s_q <= '0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            ph_q       <= ph_d;
            idx_q      <= idx_d;
            fc_q       <= fc_d;
            blink_st_q <= blink_st_d;
            din_s_q    <= din_s_d;
            dp_s_q     <= dp_s_d;
            blank_s_q  <= blank_s_d;
            blink_s_q  <= blink_s_d;
            lz_s_q     <= lz_s_d;
            bright_s_q <= bright_s_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.SEG         = seg_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_hetszegmens_n.sv
// tb_hetszegmens_n: scoreboard bench for hetszegmens_n (DIGITS=4, DIV=8, BLINK_FRAMES=2).
// Each frame's expected AN/SEG/frame_start sequence is queued when its inputs are
// applied; the monitor starts popping at a frame_start and compares every clock.
module tb_hetszegmens_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hetszegmens_if #(.DIGITS(4)) bus ();

    hetszegmens_n #(
        .DIGITS       (4),
        .CLK_HZ       (8000),
        .SCAN_HZ      (1000),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  dp, blank, blink;
        logic        lz;
        logic [2:0]  br;
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0} lit patterns
        logic [3:0]  dark;   // digits dark for the whole frame
    } row_t;

    exp_t q[$];
    row_t rows[10];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    function automatic row_t mk_row(logic [15:0] din, logic [3:0] dp, logic [3:0] blank,
                                    logic [3:0] blink, logic lz, logic [2:0] br,
                                    logic [31:0] segs, logic [3:0] dark);
        row_t r;
        r.din = din; r.dp = dp; r.blank = blank; r.blink = blink;
        r.lz = lz; r.br = br; r.segs = segs; r.dark = dark;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame = 4 slots x 8 one-clock phases.
    task automatic push_frame(input logic [31:0] segs, input logic [3:0] dark, input logic [2:0] br);
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 8; p++) begin
                exp_t e;
                logic lit;
                lit   = !dark[s] && (p <= int'(br));
                e.an  = lit ? ~(4'b0001 << s) : 4'hF;
                e.seg = lit ? segs[8*s +: 8] : 8'hFF;
                e.fs  = (s == 0 && p == 0);
                q.push_back(e);
            end
        end
    endtask

    task automatic apply_row(input row_t r);
        bus.din    = r.din;
        bus.dp     = r.dp;
        bus.blank  = r.blank;
        bus.blink  = r.blink;
        bus.lz_en  = r.lz;
        bus.bright = r.br;
        push_frame(r.segs, r.dark, r.br);
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_start !== 1'b1 && n < 64);
        if (bus.frame_start !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no frame_start within 64 clocks", name);
        end
    endtask

    // Releases reset on a falling edge and checks the first frame_start lands on clock 9.
    task automatic release_and_count(input string name);
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (bus.frame_start !== 1'b1 && n < 40);
        chk(name, n, 9);
    endtask

    // Monitor: pops one expectation per clock from a frame_start until the queue drains.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (mon_on && q.size() == 0) mon_on = 1'b0;
            if (!mon_on && bus.frame_start === 1'b1 && q.size() > 0) mon_on = 1'b1;
            if (mon_on) begin
                e = q.pop_front();
                n_chk++;
                if (bus.AN !== e.an || bus.SEG !== e.seg || bus.frame_start !== e.fs) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: AN=%b SEG=%h fs=%b, expected AN=%b SEG=%h fs=%b",
                             $time, bus.AN, bus.SEG, bus.frame_start, e.an, e.seg, e.fs);
                end
            end
        end
    end

    initial begin
        // Frames numbered from the first frame_start; blink state is 1 in frames 2,3,6,7.
        rows[0] = mk_row(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd7, {8'h9F, 8'h25, 8'h0D, 8'h99}, 4'b0000);
        rows[1] = mk_row(16'h00A0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd7, {8'hFF, 8'hFF, 8'h11, 8'h03}, 4'b0000);
        rows[2] = mk_row(16'h5678, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd2, {8'h49, 8'h41, 8'h1F, 8'h01}, 4'b0000);
        rows[3] = mk_row(16'hBCEF, 4'b0100, 4'b0000, 4'b0001, 1'b0, 3'd7, {8'hC1, 8'h62, 8'h61, 8'h71}, 4'b0000);
        rows[4] = mk_row(16'hBCEF, 4'b0100, 4'b0000, 4'b0001, 1'b0, 3'd7, {8'hC1, 8'h62, 8'h61, 8'h71}, 4'b0000);
        rows[5] = mk_row(16'hBCEF, 4'b0100, 4'b0000, 4'b0001, 1'b0, 3'd7, {8'hC1, 8'h62, 8'h61, 8'h71}, 4'b0001);
        rows[6] = mk_row(16'hBCEF, 4'b0100, 4'b0000, 4'b0001, 1'b0, 3'd7, {8'hC1, 8'h62, 8'h61, 8'h71}, 4'b0001);
        rows[7] = mk_row(16'hBCEF, 4'b0100, 4'b0000, 4'b0001, 1'b0, 3'd7, {8'hC1, 8'h62, 8'h61, 8'h71}, 4'b0000);
        rows[8] = mk_row(16'h0009, 4'b1000, 4'b0010, 4'b0000, 1'b1, 3'd7, {8'hFE, 8'hFF, 8'hFF, 8'h09}, 4'b0010);
        rows[9] = mk_row(16'hD0D1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd4, {8'h85, 8'h03, 8'h85, 8'h9F}, 4'b0000);

        apply_row(rows[0]);
        repeat (3) @(negedge clk);
        chk("reset_AN", 32'(bus.AN), 32'hF);
        chk("reset_SEG", 32'(bus.SEG), 32'hFF);
        chk("reset_frame_start", 32'(bus.frame_start), 32'h0);

        release_and_count("first_frame_start_clock");

        // Next frame's inputs are applied mid-frame; the running frame must not change.
        for (int k = 1; k < 10; k++) begin
            repeat (10) @(negedge clk);
            apply_row(rows[k]);
            wait_fs("frame_start_period");
        end
        wait_fs("frame_start_after_last_row");

        // Two clocks into digit 0's slot of the row-10 display, then reset between edges.
        repeat (2) @(negedge clk);
        chk("pre_reset_AN", 32'(bus.AN), 32'hE);
        chk("pre_reset_SEG", 32'(bus.SEG), 32'h9F);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_AN", 32'(bus.AN), 32'hF);
        chk("async_reset_SEG", 32'(bus.SEG), 32'hFF);
        chk("async_reset_frame_start", 32'(bus.frame_start), 32'h0);
        chk("queue_empty_at_reset", q.size(), 0);

        apply_row(rows[0]);
        repeat (2) @(negedge clk);
        chk("held_reset_AN", 32'(bus.AN), 32'hF);
        release_and_count("restart_frame_start_clock");

        for (int n = 0; n < 40 && q.size() > 0; n++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
